// File: rtl/alu_multicycle.sv
// alu_multicycle: integer ALU with single-cycle logic/add/shift operations and
// iterative MUL (shift-add) and signed DIV/MOD (restoring) datapaths.
//
// Optional build macro: ALU_MUL_FAST_EN
//   defined   -> MUL uses a combinational multiplier and completes in one cycle
//   undefined -> MUL iterates one bit per cycle, done at T+WIDTH+1
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   start    request strobe, accepted only while ready=1
//   op       4-bit operation code
//   d0, d1   signed operands (WIDTH bits)
//   ready    idle, a request may be issued
//   busy     complement of ready
//   done     one-cycle completion pulse, dout valid
//   dout     result, held until the next done
//   divzero  with done: DIV/MOD by zero
//   illegal  with done: unimplemented op
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             divzero,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifndef ALU_MUL_FAST_EN
  localparam logic [1:0] S_MUL  = 2'd1;
`endif
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_OR  = 4'h0;
  localparam logic [3:0] OP_XOR = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SAR = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // a: multiplicand / dividend-then-quotient; b: multiplier / divisor
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // acc: product accumulator / partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             is_mod_q, is_mod_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             divzero_q, divzero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic             big_shift;
  logic [SHW-1:0]   shamt;
`ifndef ALU_MUL_FAST_EN
  logic [WIDTH-1:0] mul_sum;
`endif

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_mod_d  = is_mod_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    done_d    = 1'b0;
    dout_d    = dout_q;
    divzero_d = 1'b0;
    illegal_d = 1'b0;

    // Any set bit above the low SHW bits means the shift is at least WIDTH
    big_shift = |(d1 >> SHW);
    shamt     = d1[SHW-1:0];

    // One restoring-division step: shift in the next dividend bit, try subtract
    rem_shift = {acc_q, a_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, b_q};
`ifndef ALU_MUL_FAST_EN
    mul_sum   = b_q[0] ? (acc_q + a_q) : acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (op)
            OP_OR:  dout_d = d0 | d1;
            OP_XOR: dout_d = d0 ^ d1;
            OP_AND: dout_d = d0 & d1;
            OP_ADD: dout_d = d0 + d1;
            OP_SUB: dout_d = d0 - d1;
`ifdef ALU_MUL_FAST_EN
            OP_MUL: dout_d = WIDTH'(d0 * d1);
`else
            OP_MUL: begin
              done_d  = 1'b0;
              state_d = S_MUL;
              cnt_d   = '0;
              acc_d   = '0;
              a_d     = d0;
              b_d     = d1;
            end
`endif
            OP_SHL: dout_d = big_shift ? '0 : (d0 << shamt);
            OP_SAR: dout_d = big_shift ? {WIDTH{d0[WIDTH-1]}}
                                       : WIDTH'($signed(d0) >>> shamt);
            OP_DIV, OP_MOD: begin
              if (d1 == '0) begin
                dout_d    = '0;
                divzero_d = 1'b1;
              end else begin
                // Magnitudes fit in WIDTH unsigned bits, including the most-negative value
                done_d   = 1'b0;
                state_d  = S_DIV;
                cnt_d    = '0;
                acc_d    = '0;
                a_d      = d0[WIDTH-1] ? (WIDTH'(0) - d0) : d0;
                b_d      = d1[WIDTH-1] ? (WIDTH'(0) - d1) : d1;
                is_mod_d = op[0];
                q_neg_d  = d0[WIDTH-1] ^ d1[WIDTH-1];
                r_neg_d  = d0[WIDTH-1];
              end
            end
            default: begin
              dout_d    = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end

`ifndef ALU_MUL_FAST_EN
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          dout_d  = mul_sum;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif

      S_DIV: begin
        if (!rem_trial[WIDTH]) begin
          acc_d = rem_trial[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Most-negative / -1 negates 2^(WIDTH-1) back onto itself, as required
        if (is_mod_q) begin
          dout_d = r_neg_q ? (WIDTH'(0) - acc_q) : acc_q;
        end else begin
          dout_d = q_neg_q ? (WIDTH'(0) - a_q) : a_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_mod_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      divzero_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_mod_q  <= is_mod_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      divzero_q <= divzero_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dout    = dout_q;
  assign divzero = divzero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32), randomized against a
// behavioural model built on 64-bit signed arithmetic.
module tb_alu_multicycle;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic         ready, busy, done, divzero, illegal;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d0(d0), .d1(d1),
    .ready(ready), .busy(busy), .done(done), .dout(dout),
    .divzero(divzero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {illegal, divzero, result}
  function automatic logic [W+1:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb;
    logic [W-1:0] r;
    logic dz, il;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; dz = 1'b0; il = 1'b0;
    case (o)
      4'h0: r = a | b;
      4'h1: r = a ^ b;
      4'h2: r = a & b;
      4'h4: r = W'(sa + sb);
      4'h5: r = W'(sa - sb);
      4'h6: r = W'(sa * sb);
      4'h8: r = (b >= W) ? '0 : W'(sa << b[5:0]);
      4'h9: r = (b >= W) ? {W{a[W-1]}} : W'(sa >>> b[5:0]);
      4'hA: if (b == '0) dz = 1'b1; else r = W'(sa / sb);
      4'hB: if (b == '0) dz = 1'b1; else r = W'(sa % sb);
      default: il = 1'b1;
    endcase
    return {il, dz, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input logic [W-1:0] b);
`ifdef ALU_MUL_FAST_EN
    if (o == 4'h6) return 1;
`else
    if (o == 4'h6) return W + 1;
`endif
    if ((o == 4'hA || o == 4'hB) && b != '0) return W + 2;
    return 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return MIN_NEG;
      3: return W'($urandom_range(0, 70));
      4: return W'(0) - W'($urandom_range(1, 70));
      default: return W'($urandom);
    endcase
  endfunction

  // Present a request before the edge, leave the bench #1 after the accept edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; d0 = a; d1 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); d0 = W'($urandom); d1 = W'($urandom);
  endtask

  // Latency counted from the accept edge; rdy_seen flags ready=1 before done
  task automatic wait_done(output int lat, output bit ok, output bit rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (!done && lat < 80) begin
      if (ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    ok = done;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W+1:0] e;
    int lat, el;
    bit ok, rs;
    e = model(o, a, b);
    el = exp_lat(o, b);
    issue(o, a, b);
    wait_done(lat, ok, rs);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout op=%h d0=%h d1=%h: no done within 80 cycles", tag, o, a, b);
      return;
    end
    n_checks++;
    if (dout !== e[W-1:0]) begin
      n_fail++;
      $display("FAIL %s dout op=%h d0=%h d1=%h got %h want %h", tag, o, a, b, dout, e[W-1:0]);
    end
    n_checks++;
    if ({illegal, divzero} !== e[W+1:W]) begin
      n_fail++;
      $display("FAIL %s flags op=%h d1=%h got il/dz=%b want %b", tag, o, b,
               {illegal, divzero}, e[W+1:W]);
    end
    n_checks++;
    if (lat != el) begin
      n_fail++;
      $display("FAIL %s latency op=%h got %0d want %0d", tag, o, lat, el);
    end
    n_checks++;
    if (rs) begin
      n_fail++;
      $display("FAIL %s ready high while busy op=%h got 1 want 0", tag, o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = 4'h4; d0 = 3; d1 = 7;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, busy, done, divzero, illegal} !== 5'b10000 || dout !== '0) begin
      n_fail++;
      $display("FAIL reset_state got r/b/d/dz/il=%b dout=%h want 10000 dout=0",
               {ready, busy, done, divzero, illegal}, dout);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins_start got done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 4'h4; d0 = 3; d1 = 7;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || dout !== W'(10) || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_add got done=%b ready=%b dout=%h want 1 1 0000000a", done, ready, dout);
    end
    op = 4'h9; d0 = MIN_NEG; d1 = 4;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || dout !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL b2b_sar got done=%b dout=%h want 1 f8000000", done, dout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width got done=%b want 0", done);
    end
  endtask

  task automatic test_directed();
    run_op("mul_plan", 4'h6, W'(-6), W'(7));
    run_op("div_plan", 4'hA, W'(-7), W'(2));
    run_op("mod_plan", 4'hB, W'(-7), W'(2));
    run_op("mod_plan2", 4'hB, W'(7), W'(-2));
    run_op("min_div_m1", 4'hA, MIN_NEG, '1);
    run_op("min_mod_m1", 4'hB, MIN_NEG, '1);
    run_op("divzero", 4'hA, W'(5), '0);
    run_op("modzero", 4'hB, W'(5), '0);
    run_op("illegal7", 4'h7, W'(9), W'(9));
    run_op("shl_big", 4'h8, W'(1), W'(40));
    run_op("shl_31", 4'h8, W'(1), W'(31));
    run_op("sar_32", 4'h9, MIN_NEG, W'(32));
    run_op("mul_minneg", 4'h6, MIN_NEG, '1);
  endtask

  task automatic test_random();
    logic [3:0] o;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom);
      run_op("rand", o, pick(), pick());
    end
  endtask

  task automatic test_abort();
    int ndone;
    run_op("pre_abort_add", 4'h4, W'(3), W'(7));
    issue(4'hA, W'(12345), W'(7));
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || dout !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state got ready=%b busy=%b done=%b dout=%h want 1 0 0 0",
               ready, busy, done, dout);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    logic [W-1:0] last;
    issue(4'h6, W'(-6), W'(7));
    ndone = 0; last = '0;
    @(negedge clk);
    start = 1'b1; op = 4'h4; d0 = 1; d1 = 1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (i == 2) start = 1'b0;
      if (done) begin ndone++; last = dout; end
    end
    start = 1'b0;
    n_checks++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL busy_ignore_count got %0d done pulses want 1", ndone);
    end
    n_checks++;
    if (last !== W'(-42)) begin
      n_fail++;
      $display("FAIL busy_ignore_result got %h want %h", last, W'(-42));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_random();
    test_abort();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
